// File: rtl/alt_vipitc120_common_cfg_xfer.sv
// alt_vipitc120_common_cfg_xfer: toggle-handshake transfer of a config word into sync_clock,
// applied to the timing generator at a frame boundary.
module alt_vipitc120_common_cfg_xfer #(
  parameter int WIDTH = 32,
  parameter int SYNC_STAGES = 2,
  parameter int APPLY_ON_BOUNDARY = 1
) (
  input  logic             rst,
  input  logic             sync_clock,
  input  logic             req_toggle_in,
  input  logic [WIDTH-1:0] data_in,
  output logic             ack_toggle_out,
  input  logic             boundary,
  input  logic             enable,
  output logic [WIDTH-1:0] cfg_out,
  output logic             cfg_update,
  output logic             busy
);
  typedef enum logic {IDLE, PENDING} state_t;
  state_t state_q, state_d;
  (* altera_attribute = "-name SYNCHRONIZER_IDENTIFICATION FORCED_IF_ASYNCHRONOUS" *)
  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] sync_d;
  logic req_seen_q, req_seen_d, ack_q, ack_d, upd_q, upd_d, busy_q, busy_d;
  logic [WIDTH-1:0] shadow_q, shadow_d, cfg_q, cfg_d;
  logic req_sync, req_pending, apply_ok;
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], req_toggle_in};
    req_sync = sync_q[SYNC_STAGES-1];
    req_pending = req_sync != req_seen_q;
    apply_ok = (APPLY_ON_BOUNDARY == 0) || boundary || !enable;
    state_d = state_q;
    req_seen_d = req_seen_q;
    shadow_d = shadow_q;
    cfg_d = cfg_q;
    ack_d = ack_q;
    busy_d = busy_q;
    upd_d = 1'b0;
    if (state_q == IDLE && req_pending) begin
      shadow_d = data_in;
      req_seen_d = req_sync;
      busy_d = 1'b1;
      state_d = PENDING;
    end else if (state_q == PENDING && apply_ok) begin
      cfg_d = shadow_q;
      upd_d = 1'b1;
      ack_d = !ack_q;
      busy_d = 1'b0;
      state_d = IDLE;
    end
  end
  always_ff @(posedge sync_clock or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      sync_q <= '0;
      req_seen_q <= 1'b0;
      shadow_q <= '0;
      cfg_q <= '0;
      ack_q <= 1'b0;
      busy_q <= 1'b0;
      upd_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sync_q <= sync_d;
      req_seen_q <= req_seen_d;
      shadow_q <= shadow_d;
      cfg_q <= cfg_d;
      ack_q <= ack_d;
      busy_q <= busy_d;
      upd_q <= upd_d;
    end
  end
  assign ack_toggle_out = ack_q;
  assign cfg_out = cfg_q;
  assign cfg_update = upd_q;
  assign busy = busy_q;
endmodule
